// File: rtl/n_bit_down_timer_if.sv
// ----------------------------------------------------------------------------
// n_bit_down_timer_if
// Groups the load handshake, run controls and status of n_bit_down_timer.
//   master : drives load_val/start/pause/abort, observes ready/count/busy/done
//   slave  : the timer itself
// Parameter WIDTH : width of load_val and count.
// ----------------------------------------------------------------------------
interface n_bit_down_timer_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] load_val;
   logic             start;
   logic             ready;
   logic             pause;
   logic             abort;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             done;

   modport master (
      output load_val, start, pause, abort,
      input  ready, count, busy, done
   );

   modport slave (
      input  load_val, start, pause, abort,
      output ready, count, busy, done
   );
endinterface

// File: rtl/n_bit_down_timer.sv
// ----------------------------------------------------------------------------
// n_bit_down_timer
// Loadable down-counting timer. A start value is accepted through a
// start/ready handshake; the count then drops by one per unpaused clock and
// a one-cycle done pulse marks terminal count.
//
// Ports
//   clk  : clock, rising edge
//   clr  : asynchronous active-high reset
//   tmr  : n_bit_down_timer_if.slave
//          load_val, start, pause, abort (in); ready, count, busy, done (out)
//
// Build option
//   N_BIT_DOWN_TIMER_RELOAD_EN : auto-reload. The value of the last accepted
//   handshake is reloaded at terminal count and the timer keeps running until
//   abort or clr.
// ----------------------------------------------------------------------------
module n_bit_down_timer #(
   parameter int WIDTH = 8
) (
   input logic                clk,
   input logic                clr,
   n_bit_down_timer_if.slave  tmr
);

   typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_count;
   logic             r_busy;
   logic             r_done;

   state_t           w_state_nxt;
   logic [WIDTH-1:0] w_count_nxt;
   logic             w_busy_nxt;
   logic             w_done_nxt;
   logic             w_hs;

   assign w_hs = tmr.start && (r_state == S_IDLE);

`ifdef N_BIT_DOWN_TIMER_RELOAD_EN
   logic [WIDTH-1:0] r_reload;

   always_ff @(posedge clk or posedge clr) begin
      if (clr)       r_reload <= '0;
      else if (w_hs) r_reload <= tmr.load_val;
   end
`endif

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state <= S_IDLE;
         r_count <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;   // done is a pulse: cleared unless re-asserted below
      case (r_state)
         S_IDLE: begin
            if (w_hs) begin
               if (tmr.load_val != '0) begin
                  w_count_nxt = tmr.load_val;
                  w_busy_nxt  = 1'b1;
                  w_state_nxt = S_RUN;
               end else begin
                  // zero-length wait completes on the handshake edge itself
                  w_done_nxt  = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (tmr.abort) begin
               w_count_nxt = '0;
               w_busy_nxt  = 1'b0;
               w_state_nxt = S_IDLE;
            end else if (!tmr.pause) begin
               if (r_count > WIDTH'(1)) begin
                  w_count_nxt = r_count - WIDTH'(1);
               end else begin
                  // terminal count (count is never 0 while running)
                  w_done_nxt  = 1'b1;
`ifdef N_BIT_DOWN_TIMER_RELOAD_EN
                  w_count_nxt = r_reload;
`else
                  w_count_nxt = '0;
                  w_busy_nxt  = 1'b0;
                  w_state_nxt = S_IDLE;
`endif
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign tmr.ready = (r_state == S_IDLE);
   assign tmr.count = r_count;
   assign tmr.busy  = r_busy;
   assign tmr.done  = r_done;

endmodule

// File: doc/n_bit_down_timer.md
# n_bit_down_timer

- Loadable down-counting timer; the counterpart of the free-running up-counter.
- Accepts a start value through a valid/ready handshake and counts down once per clock.
- Signals terminal count with a one-cycle `done` pulse.
- Sits beside the up-counter in timing and delay logic, where a block must wait a programmed number of cycles.

## Interface
- `WIDTH`, default 8 — width of the load value and the count.
- `clk` input 1 — clock; every register updates on the rising edge.
- `clr` input 1 — reset, asynchronous, active-high.
- `load_val` input WIDTH — start value, sampled when the start handshake completes.
- `start` input 1 — start request; the handshake completes on an edge where `start` and `ready` are both high.
- `ready` output 1 — high only in IDLE.
- `pause` input 1 — while high in RUN, the count holds.
- `abort` input 1 — synchronous cancel; ends the run without a `done` pulse.
- `count` output WIDTH — current count value, registered.
- `busy` output 1 — high in RUN; registered.
- `done` output 1 — one-cycle terminal-count pulse; registered.

## Operation
- States: IDLE and RUN; 1-bit state register.
- `ready` is decoded from state: `ready` = (state == IDLE).
- While `clr` is high, independent of `clk`:
  - state = IDLE
  - `count` = 0
  - `busy` = 0
  - `done` = 0
  - therefore `ready` = 1
- IDLE, start handshake with `load_val` = L ≠ 0:
  - `count` ← L, `busy` ← 1, state ← RUN.
- IDLE, start handshake with L = 0:
  - `done` ← 1 for one cycle; state stays IDLE; `count` stays 0.
- IDLE, no handshake: `count` holds.
- RUN, priority per edge is abort > pause > decrement:
  - `abort` = 1: `count` ← 0, `busy` ← 0, state ← IDLE, `done` stays 0.
  - `pause` = 1: all registers hold.
  - otherwise, when `count` > 1: `count` ← `count` − 1.
  - otherwise, when `count` = 1 (terminal count): `count` ← 0, `done` ← 1, `busy` ← 0, state ← IDLE.
- `done` clears on the edge after it is set, unless terminal count recurs on that edge.
- `start` is ignored while `ready` = 0; `load_val` is ignored outside the handshake.
- `count` never wraps below 0; decrement arithmetic is unsigned at WIDTH bits.
- `pause` and `abort` have no effect in IDLE.
- Reset mid-run discards the run immediately; no `done` pulse is produced.

## Timing
- Handshake at edge t with L ≥ 1:
  - `count` = L and `busy` = 1 after edge t.
  - `count` = 0 and `done` = 1 after edge t+L, when no pause occurs.
- Each cycle with `pause` high adds exactly one cycle of latency.
- `ready` returns to 1 in the same cycle that `done` is high. A new handshake on the next edge (t+L+1) is accepted: back-to-back runs with zero gap.
- Handshake with L = 0 at edge t: `done` = 1 after edge t; `busy` stays 0.
- `abort` at edge t: `busy` = 0 and `ready` = 1 after edge t.

## Configuration
- `N_BIT_DOWN_TIMER_RELOAD_EN` — compiles in auto-reload mode.
- Defined:
  - A WIDTH-bit reload register captures `load_val` at each accepted handshake.
  - At terminal count: `count` ← reload register, `done` ← 1, state stays RUN, `busy` stays 1, `ready` stays 0.
  - `done` therefore pulses every L cycles, excluding paused cycles.
  - Only `abort` or `clr` returns the block to IDLE.
  - A handshake with L = 0 still behaves as one-shot: `done` pulses and the block stays in IDLE.
  - Reset value of the reload register: 0.
- Undefined:
  - One-shot behaviour exactly as described under Operation; no reload register.

## Test plan
- `clr` = 1 mid-run with `count` = 5 -> immediately (asynchronously) `count` = 0, `busy` = 0, `done` = 0, `ready` = 1; no `done` pulse after release.
- Handshake with L = 4, no pause -> `count` = 4, 3, 2, 1, 0 on successive edges; `done` high exactly one cycle with `count` = 0 after the 4th edge following the handshake; `ready` = 1 in that cycle.
- Handshake with L = 3, `pause` high for 2 cycles after the first decrement -> `count` = 3, 2, 2, 2, 1, 0; `done` arrives 2 cycles later than unpaused.
- Handshake with L = 0 -> `done` pulses once on the next edge, `busy` stays 0; then `start` held high with L = 255 -> accepted; `count` = 255 and reaches 0 after 255 further edges; `start` asserted during RUN is ignored.
- Handshake with L = 6, then `pause` = 1 and `abort` = 1 together at `count` = 3 -> abort wins; `count` = 0, IDLE, no `done`. Back-to-back: L = 2 then L = 1 accepted on the edge after `done` -> `done` pulses at t+2 and t+4.
- Macro defined, L = 3, run for 10 cycles -> `count` = 3, 2, 1, 3, 2, 1, …; `done` pulses every 3 cycles; `busy` stays 1 throughout; `abort` returns the block to IDLE with `count` = 0.
